// File: rtl/storage_seq_pkg.sv
// Shared encodings for the LEG storage sequencer: opcodes, fault codes and FSM states.
package storage_seq_pkg;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_LOAD    = 3'd1;
    localparam logic [2:0] OP_STORE   = 3'd2;
    localparam logic [2:0] OP_PUSH    = 3'd3;
    localparam logic [2:0] OP_POP     = 3'd4;
    localparam logic [2:0] OP_CALL    = 3'd5;
    localparam logic [2:0] OP_RET     = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    localparam logic [1:0] FLT_NONE = 2'd0;
    localparam logic [1:0] FLT_OVF  = 2'd1;
    localparam logic [1:0] FLT_UNF  = 2'd2;
    localparam logic [1:0] FLT_ILL  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR    = 2'd1,
        ST_RD    = 2'd2,
        ST_RDATA = 2'd3
    } seq_state_t;

endpackage

// File: rtl/stack_pointer_unit.sv
// Downward-growing stack pointer with full/empty flags; sp addresses the next free slot.
module stack_pointer_unit #(
    parameter logic [7:0]  STACK_BASE  = 8'hFF,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    output logic [7:0] sp,
    output logic [7:0] sp_plus1,
    output logic       full,
    output logic       empty
);

    localparam logic [7:0] DEPTH8 = STACK_DEPTH[7:0];

    logic [7:0] used;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= STACK_BASE;
        end else if (push && !pop) begin
            sp <= sp - 8'd1;
        end else if (pop && !push) begin
            sp <= sp + 8'd1;
        end
    end

    // Occupancy is taken mod 256 so a base near 8'h00 still wraps correctly.
    assign used     = STACK_BASE - sp;
    assign sp_plus1 = sp + 8'd1;
    assign full     = (used == DEPTH8);
    assign empty    = (sp == STACK_BASE);

endmodule

// File: rtl/storage_sequencer.sv
// LEG storage-path sequencer: one storage op at a time onto a single-port RAM that also holds the call stack.
module storage_sequencer
    import storage_seq_pkg::*;
#(
    parameter logic [7:0]  STACK_BASE  = 8'hFF,
    parameter int unsigned STACK_DEPTH = 16,
    parameter logic [7:0]  RET_OFFSET  = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    input  logic [7:0] cur_counter,
    output logic       ram_en,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       jump_valid,
    output logic [7:0] jump_target,
    output logic [7:0] sp,
    output logic       stack_empty,
    output logic       stack_full,
    output logic       fault,
    output logic [1:0] fault_code
);

    seq_state_t state_q, state_d;
    logic [2:0] op_q, op_d;
    logic       accept, is_read_op, ovf, unf, ill, rejected;
    logic       push_stb, pop_stb, op_is_ret;
    logic [7:0] sp_plus1;
    logic [7:0] rsp_data_q, rsp_data_d, jump_target_q, jump_target_d;
    logic       ram_en_d, ram_we_d, rsp_valid_d, jump_valid_d, fault_d;
    logic [7:0] ram_addr_d, ram_wdata_d;
    logic [1:0] fault_code_d;

    stack_pointer_unit #(
        .STACK_BASE (STACK_BASE),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_sp (
        .clk     (clk),
        .rst     (rst),
        .push    (push_stb),
        .pop     (pop_stb),
        .sp      (sp),
        .sp_plus1(sp_plus1),
        .full    (stack_full),
        .empty   (stack_empty)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign is_read_op = (req_op == OP_LOAD) || (req_op == OP_POP) || (req_op == OP_RET);
    assign ovf        = ((req_op == OP_PUSH) || (req_op == OP_CALL)) && stack_full;
    assign unf        = ((req_op == OP_POP) || (req_op == OP_RET)) && stack_empty;
    assign ill        = (req_op == OP_ILLEGAL);
    assign rejected   = ovf || unf || ill;
    assign op_is_ret  = (op_q == OP_RET);

    // sp moves on the closing edge of the RAM cycle; a rejected op parks in WR with fault high and no strobe.
    assign push_stb = (state_q == ST_WR) && !fault && ((op_q == OP_PUSH) || (op_q == OP_CALL));
    assign pop_stb  = (state_q == ST_RD) && ((op_q == OP_POP) || op_is_ret);

    // Read data arrives during RDATA, so it is forwarded straight through and held afterwards.
    assign rsp_data    = (state_q == ST_RDATA && !op_is_ret) ? ram_rdata : rsp_data_q;
    assign jump_target = (state_q == ST_RDATA &&  op_is_ret) ? ram_rdata : jump_target_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_NOP;
            ram_en        <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr      <= 8'd0;
            ram_wdata     <= 8'd0;
            rsp_valid     <= 1'b0;
            rsp_data_q    <= 8'd0;
            jump_valid    <= 1'b0;
            jump_target_q <= 8'd0;
            fault         <= 1'b0;
            fault_code    <= FLT_NONE;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            ram_en        <= ram_en_d;
            ram_we        <= ram_we_d;
            ram_addr      <= ram_addr_d;
            ram_wdata     <= ram_wdata_d;
            rsp_valid     <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            jump_valid    <= jump_valid_d;
            jump_target_q <= jump_target_d;
            fault         <= fault_d;
            fault_code    <= fault_code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_op == OP_NOP)  state_d = ST_IDLE;
                    else if (rejected)     state_d = ST_WR;
                    else if (is_read_op)   state_d = ST_RD;
                    else                   state_d = ST_WR;
                end
            end
            ST_WR:    state_d = ST_IDLE;
            ST_RD:    state_d = ST_RDATA;
            ST_RDATA: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d          = op_q;
        ram_en_d      = 1'b0;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr;
        ram_wdata_d   = ram_wdata;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        jump_valid_d  = 1'b0;
        jump_target_d = jump_target_q;
        fault_d       = 1'b0;
        fault_code_d  = fault_code;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = req_op;
                    if (rejected) begin
                        fault_d      = 1'b1;
                        fault_code_d = ill ? FLT_ILL : (ovf ? FLT_OVF : FLT_UNF);
                    end else begin
                        case (req_op)
                            OP_LOAD: begin
                                ram_en_d   = 1'b1;
                                ram_addr_d = req_addr;
                            end
                            OP_STORE: begin
                                ram_en_d    = 1'b1;
                                ram_we_d    = 1'b1;
                                ram_addr_d  = req_addr;
                                ram_wdata_d = req_data;
                            end
                            OP_PUSH: begin
                                ram_en_d    = 1'b1;
                                ram_we_d    = 1'b1;
                                ram_addr_d  = sp;
                                ram_wdata_d = req_data;
                            end
                            OP_CALL: begin
                                ram_en_d      = 1'b1;
                                ram_we_d      = 1'b1;
                                ram_addr_d    = sp;
                                ram_wdata_d   = cur_counter + RET_OFFSET;
                                jump_valid_d  = 1'b1;
                                jump_target_d = req_addr;
                            end
                            OP_POP, OP_RET: begin
                                ram_en_d   = 1'b1;
                                ram_addr_d = sp_plus1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_RD: begin
                if (op_is_ret) jump_valid_d = 1'b1;
                else           rsp_valid_d  = 1'b1;
            end
            ST_RDATA: begin
                if (op_is_ret) jump_target_d = ram_rdata;
                else           rsp_data_d    = ram_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_storage_sequencer.sv
// Directed bench: a default-depth sequencer and a depth-2 twin share one stimulus stream, each with its own RAM.
module tb_storage_sequencer;
    import storage_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_op = OP_NOP;
    logic [7:0] req_addr = 8'd0, req_data = 8'd0, cur_counter = 8'd0;

    logic       req_ready, ram_en, ram_we, rsp_valid, jump_valid, stack_empty, stack_full, fault;
    logic [7:0] ram_addr, ram_wdata, rsp_data, jump_target, sp;
    logic [7:0] ram_rdata = 8'd0;
    logic [1:0] fault_code;

    logic       req_ready_b, ram_en_b, ram_we_b, rsp_valid_b, jump_valid_b, stack_empty_b, stack_full_b, fault_b;
    logic [7:0] ram_addr_b, ram_wdata_b, rsp_data_b, jump_target_b, sp_b;
    logic [7:0] ram_rdata_b = 8'd0;
    logic [1:0] fault_code_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    storage_sequencer u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .cur_counter(cur_counter),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .jump_valid(jump_valid), .jump_target(jump_target),
        .sp(sp), .stack_empty(stack_empty), .stack_full(stack_full), .fault(fault), .fault_code(fault_code)
    );

    storage_sequencer #(.STACK_DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_b), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .cur_counter(cur_counter),
        .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .jump_valid(jump_valid_b), .jump_target(jump_target_b),
        .sp(sp_b), .stack_empty(stack_empty_b), .stack_full(stack_full_b), .fault(fault_b), .fault_code(fault_code_b)
    );

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem_a[ram_addr] <= ram_wdata;
            else        ram_rdata       <= mem_a[ram_addr];
        end
        if (ram_en_b) begin
            if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
            else          ram_rdata_b       <= mem_b[ram_addr_b];
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single cycle; returns mid-cycle T+1.
    task automatic send(input logic [2:0] op, input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = OP_NOP;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sp", sp, 8'hFF);
        chk("rst_empty", stack_empty, 1'b1);
        chk("rst_full", stack_full, 1'b0);
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_fault_code", fault_code, 2'd0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        rst = 1'b1;

        send(OP_STORE, 8'h10, 8'hA5);
        chk("st_en", ram_en, 1'b1);
        chk("st_we", ram_we, 1'b1);
        chk("st_addr", ram_addr, 8'h10);
        chk("st_wdata", ram_wdata, 8'hA5);
        chk("st_busy", req_ready, 1'b0);
        step();
        chk("st_ready", req_ready, 1'b1);
        chk("st_en_off", ram_en, 1'b0);

        send(OP_LOAD, 8'h10, 8'h00);
        chk("ld_en", ram_en, 1'b1);
        chk("ld_we", ram_we, 1'b0);
        chk("ld_addr", ram_addr, 8'h10);
        chk("ld_busy", req_ready, 1'b0);
        chk("ld_rsp_early", rsp_valid, 1'b0);
        step();
        chk("ld_rsp_valid", rsp_valid, 1'b1);
        chk("ld_rsp_data", rsp_data, 8'hA5);
        chk("ld_busy2", req_ready, 1'b0);
        step();
        chk("ld_rsp_off", rsp_valid, 1'b0);
        chk("ld_ready", req_ready, 1'b1);

        send(OP_PUSH, 8'h00, 8'h11);
        chk("push1_addr", ram_addr, 8'hFF);
        chk("push1_wdata", ram_wdata, 8'h11);
        chk("push1_b_we", ram_we_b, 1'b1);
        chk("push1_b_wdata", ram_wdata_b, 8'h11);
        step();
        chk("push1_sp", sp, 8'hFE);
        send(OP_PUSH, 8'h00, 8'h22);
        chk("push2_addr", ram_addr, 8'hFE);
        step();
        chk("push2_sp", sp, 8'hFD);
        chk("b_full", stack_full_b, 1'b1);
        send(OP_PUSH, 8'h00, 8'h33);
        chk("push3_addr", ram_addr, 8'hFD);
        chk("push3_we", ram_we, 1'b1);
        chk("b_ovf_fault", fault_b, 1'b1);
        chk("b_ovf_code", fault_code_b, 2'd1);
        chk("b_ovf_no_ram", ram_en_b, 1'b0);
        chk("b_ovf_busy", req_ready_b, 1'b0);
        chk("fault_clean", fault, 1'b0);
        step();
        chk("push3_sp", sp, 8'hFC);
        chk("b_ovf_sp", sp_b, 8'hFD);
        chk("b_ovf_pulse_end", fault_b, 1'b0);

        send(OP_POP, 8'h00, 8'h00);
        chk("pop1_addr", ram_addr, 8'hFD);
        chk("pop1_we", ram_we, 1'b0);
        chk("b_pop1_addr", ram_addr_b, 8'hFE);
        step();
        chk("pop1_valid", rsp_valid, 1'b1);
        chk("pop1_data", rsp_data, 8'h33);
        chk("b_pop1_data", rsp_data_b, 8'h22);
        step();
        send(OP_POP, 8'h00, 8'h00);
        chk("pop2_addr", ram_addr, 8'hFE);
        step();
        chk("pop2_data", rsp_data, 8'h22);
        chk("b_pop2_data", rsp_data_b, 8'h11);
        step();
        send(OP_POP, 8'h00, 8'h00);
        chk("pop3_addr", ram_addr, 8'hFF);
        chk("b_unf_fault", fault_b, 1'b1);
        chk("b_unf_code", fault_code_b, 2'd2);
        chk("b_unf_no_ram", ram_en_b, 1'b0);
        step();
        chk("pop3_data", rsp_data, 8'h11);
        chk("b_unf_no_rsp", rsp_valid_b, 1'b0);
        chk("b_unf_empty", stack_empty_b, 1'b1);
        step();
        chk("pop3_sp", sp, 8'hFF);
        chk("pop3_empty", stack_empty, 1'b1);

        cur_counter = 8'h20;
        send(OP_CALL, 8'h40, 8'h00);
        chk("call_jv", jump_valid, 1'b1);
        chk("call_target", jump_target, 8'h40);
        chk("call_addr", ram_addr, 8'hFF);
        chk("call_wdata", ram_wdata, 8'h24);
        chk("call_no_rsp", rsp_valid, 1'b0);
        chk("b_call_jv", jump_valid_b, 1'b1);
        chk("b_call_target", jump_target_b, 8'h40);
        step();
        chk("call_jv_end", jump_valid, 1'b0);
        chk("call_sp", sp, 8'hFE);
        chk("call_mem", mem_a[8'hFF], 8'h24);

        send(OP_RET, 8'h00, 8'h00);
        chk("ret_addr", ram_addr, 8'hFF);
        chk("ret_en", ram_en, 1'b1);
        chk("ret_jv_early", jump_valid, 1'b0);
        step();
        chk("ret_jv", jump_valid, 1'b1);
        chk("ret_target", jump_target, 8'h24);
        chk("ret_no_rsp", rsp_valid, 1'b0);
        step();
        chk("ret_sp", sp, 8'hFF);

        send(OP_ILLEGAL, 8'h00, 8'h00);
        chk("ill_fault", fault, 1'b1);
        chk("ill_code", fault_code, 2'd3);
        chk("ill_no_ram", ram_en, 1'b0);
        chk("ill_busy", req_ready, 1'b0);
        step();
        chk("ill_pulse_end", fault, 1'b0);
        chk("ill_ready", req_ready, 1'b1);

        send(OP_NOP, 8'h00, 8'h00);
        chk("nop_fault", fault, 1'b0);
        chk("nop_rsp", rsp_valid, 1'b0);
        chk("nop_jump", jump_valid, 1'b0);
        chk("nop_ram", ram_en, 1'b0);
        chk("nop_ready", req_ready, 1'b1);
        chk("nop_code_held", fault_code, 2'd3);

        send(OP_PUSH, 8'h00, 8'h5A);
        step();
        chk("pre_rst_sp", sp, 8'hFE);
        send(OP_POP, 8'h00, 8'h00);
        chk("rd_before_rst", ram_en, 1'b1);
        rst = 1'b0;
        #1;
        chk("rst_mid_en", ram_en, 1'b0);
        chk("rst_mid_sp", sp, 8'hFF);
        chk("rst_mid_addr", ram_addr, 8'h00);
        chk("rst_mid_code", fault_code, 2'd0);
        chk("rst_mid_target", jump_target, 8'h00);
        repeat (2) @(negedge clk);
        chk("rst_hold_rsp", rsp_valid, 1'b0);
        chk("rst_hold_data", rsp_data, 8'h00);
        chk("rst_hold_en", ram_en, 1'b0);
        rst = 1'b1;

        send(OP_LOAD, 8'h10, 8'h00);
        chk("post_ld_en", ram_en, 1'b1);
        step();
        chk("post_ld_valid", rsp_valid, 1'b1);
        chk("post_ld_data", rsp_data, 8'hA5);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/storage_sequencer.md
Name: storage_sequencer

Overview:
- Multi-cycle sequencer for the LEG storage path: one single-port data RAM that holds both plain data and the call/return stack.
- Accepts one decoded storage op at a time (LOAD, STORE, PUSH, POP, CALL, RET) over a valid/ready handshake.
- Owns the stack pointer and the overflow/underflow checks, drives the RAM port, and issues program-counter redirects for CALL and RET.
- Sits between the opcode decode stage and the RAM/counter.

Parameters:
- STACK_BASE, 8'hFF, address of the first stack slot; the stack grows downward.
- STACK_DEPTH, 16, maximum number of entries (1..255).
- RET_OFFSET, 4, added to cur_counter to form the CALL return address (one LEG instruction = 4 bytes).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request this cycle.
- req_op  in  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL, 6 RET, 7 illegal.
- req_addr  in  8  RAM address for LOAD/STORE; jump target for CALL.
- req_data  in  8  write data for STORE/PUSH.
- cur_counter  in  8  current program counter, used by CALL.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable; asserted only together with ram_en.
- ram_addr  out  8  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data, valid the cycle after a read strobe.
- rsp_valid  out  1  one-cycle pulse: rsp_data holds the LOAD/POP result.
- rsp_data  out  8  read result.
- jump_valid  out  1  one-cycle pulse: load jump_target into the PC.
- jump_target  out  8  new PC value.
- sp  out  8  stack pointer, addresses the next free slot.
- stack_empty  out  1  sp == STACK_BASE.
- stack_full  out  1  (STACK_BASE - sp) mod 256 == STACK_DEPTH.
- fault  out  1  one-cycle pulse on a rejected request.
- fault_code  out  2  last fault: 1 overflow, 2 underflow, 3 illegal op; 0 = none since reset.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM to IDLE; sp = STACK_BASE.
  - All pulses, ram_en and ram_we = 0; rsp_data, jump_target, ram_addr, ram_wdata = 0; fault_code = 0.
  - An in-flight op is abandoned; no RAM write issues after rst falls.
- FSM states: IDLE, WR, RD, RDATA.
- req_ready = 1 only in IDLE.
- Accept = req_valid & req_ready at edge T; op/addr/data/cur_counter are captured at T. Every output below is registered and listed by the cycle it is visible.
- NOP: accepted, no effect, stays in IDLE.
- STORE: T+1 WR, ram_en = ram_we = 1, ram_addr = req_addr, ram_wdata = req_data. Back in IDLE at T+2.
- LOAD:
  - T+1 RD, ram_en = 1, ram_addr = req_addr.
  - T+2 RDATA, rsp_valid = 1, rsp_data = ram_rdata.
  - IDLE at T+3.
- PUSH: T+1 WR, write req_data to mem[sp]; sp decrements at the end of T+1.
- POP:
  - T+1 RD, read mem[sp+1]; sp increments at the end of T+1.
  - T+2 rsp_valid with the popped value.
- CALL: T+1 WR, write (cur_counter + RET_OFFSET) mod 256 to mem[sp]; sp decrements; jump_valid = 1 with jump_target = req_addr in the same cycle.
- RET: T+1 RD as POP; T+2 jump_valid = 1, jump_target = ram_rdata, rsp_valid stays 0.
- Faults (checked at accept against the sp value at T):
  - PUSH/CALL while stack_full: overflow.
  - POP/RET while stack_empty: underflow.
  - req_op = 7: illegal.
  - On a fault: T+1 fault = 1 and fault_code updated. No RAM access, sp unchanged, no rsp or jump. IDLE at T+2.
- Arithmetic: all address math is 8-bit, mod 256. sp never leaves the range [STACK_BASE - STACK_DEPTH, STACK_BASE] mod 256.
- Mutual exclusion: at most one of rsp_valid, jump_valid, fault is high in any cycle. ram_we is never high without ram_en.
- Back-to-back: a new request can be accepted in the cycle the previous op returns to IDLE (next accept at T+2 for 2-cycle ops, T+3 for LOAD/POP/RET).
- Flags: stack_full/stack_empty are combinational from sp and valid at all times, including during reset.

Decomposition:
- Package storage_seq_pkg:
  - op encoding constants (OP_NOP..OP_ILLEGAL)
  - fault code constants (FLT_NONE, FLT_OVF, FLT_UNF, FLT_ILL)
  - FSM state typedef.
- Sub-module stack_pointer_unit: holds sp; inputs push/pop strobes; outputs sp, sp_plus1, full, empty. Parameterised by STACK_BASE and STACK_DEPTH.
- The top module keeps the FSM and the RAM/response muxing.

Test Plan:
- Reset, then STORE addr 8'h10 data 8'hA5, then LOAD 8'h10 -> WR strobe at T+1; rsp_valid at LOAD-accept+2 with rsp_data 8'hA5; req_ready low while busy.
- PUSH 8'h11, 8'h22, 8'h33, then three POPs -> writes at 8'hFF, FE, FD; rsp_data 8'h33, 22, 11; final sp 8'hFF and stack_empty = 1.
- cur_counter 8'h20, CALL addr 8'h40; later RET -> CALL: jump_valid at T+1 with target 8'h40 and mem[8'hFF] = 8'h24. RET: jump_valid at T+2 with target 8'h24.
- With STACK_DEPTH = 2: three PUSHes -> third gives fault pulse, fault_code 1, no ram_en, sp stays 8'hFD. A POP on an empty stack -> fault_code 2.
- req_op 7 -> fault_code 3, no RAM activity; then a NOP -> no pulses, req_ready high the next cycle.
- Assert rst during the RD cycle of a POP -> no rsp_valid; sp = 8'hFF; all outputs 0 while low; normal LOAD after release.
